// File: rtl/mux_arbiter_2to1_pkg.sv
// Shared definitions for the 2:1 mux arbiter.
// Holds the FSM state encodings and the mux-select constants used by the
// arbiter top and by anything that decodes its select line.
package mux_arb_defs;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_A = 2'b01,
        GNT_B = 2'b10
    } arb_state_e;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage : mux_arb_defs

// File: rtl/mux_arbiter_2to1_two_one_mux.sv
// two_one_mux: 1-bit 2:1 multiplexer, one slice of the arbiter datapath.
// Ports:
//   a_i   - input selected when sel_i = 0
//   b_i   - input selected when sel_i = 1
//   sel_i - select
//   y_o   - selected output
module two_one_mux (
    input  logic a_i,
    input  logic b_i,
    input  logic sel_i,
    output logic y_o
);

    assign y_o = sel_i ? b_i : a_i;

endmodule : two_one_mux

// File: rtl/mux_arbiter_2to1.sv
// mux_arbiter_2to1: round-robin arbiter sharing one WIDTH-bit 2:1 mux lane
// between requesters A and B, with a bounded hold time under contention and
// a registered, valid-flagged output.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   req_a, req_b    - level requests
//   din_a, din_b    - lane data
//   gnt_a, gnt_b    - registered grants (mutually exclusive)
//   sel             - registered mux select (0 = A, 1 = B)
//   dout            - registered mux output, held while not valid
//   dout_valid      - dout carries data sampled during a grant cycle
module mux_arbiter_2to1
    import mux_arb_defs::*;
#(
    parameter int unsigned WIDTH    = 1,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] din_a,
    input  logic [WIDTH-1:0] din_b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             sel,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid
);

    localparam int unsigned HCW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HCW-1:0] HOLD_MAX = HCW'(MAX_HOLD - 1);

    arb_state_e       state_q, state_d;
    logic [HCW-1:0]   hold_cnt_q, hold_cnt_d;
    logic             last_q, last_d;
    logic             sel_q, sel_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_valid_q, dout_valid_d;
    logic [WIDTH-1:0] mux_y;
    logic             granted;

    for (genvar i = 0; i < WIDTH; i++) begin : g_mux
        two_one_mux u_mux (
            .a_i   (din_a[i]),
            .b_i   (din_b[i]),
            .sel_i (sel_q),
            .y_o   (mux_y[i])
        );
    end

    assign granted = (state_q != IDLE);

    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        last_d       = last_q;
        sel_d        = sel_q;
        dout_d       = dout_q;
        dout_valid_d = granted;

        unique case (state_q)
            IDLE: begin
                // On a tie the side that did not win last time goes first.
                if (req_a && req_b)
                    state_d = (last_q == SEL_B) ? GNT_A : GNT_B;
                else if (req_a)
                    state_d = GNT_A;
                else if (req_b)
                    state_d = GNT_B;
            end
            GNT_A: begin
                if (!req_a)
                    state_d = req_b ? GNT_B : IDLE;
                else if (req_b && hold_cnt_q == HOLD_MAX)
                    state_d = GNT_B;
            end
            GNT_B: begin
                if (!req_b)
                    state_d = req_a ? GNT_A : IDLE;
                else if (req_a && hold_cnt_q == HOLD_MAX)
                    state_d = GNT_A;
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q)
            hold_cnt_d = '0;
        else if (granted && hold_cnt_q != HOLD_MAX)
            hold_cnt_d = hold_cnt_q + HCW'(1);

        if (state_d != state_q && state_d == GNT_A)
            last_d = SEL_A;
        else if (state_d != state_q && state_d == GNT_B)
            last_d = SEL_B;

        // Select follows the next grant; IDLE keeps the previous select.
        if (state_d == GNT_A)
            sel_d = SEL_A;
        else if (state_d == GNT_B)
            sel_d = SEL_B;

        if (granted)
            dout_d = mux_y;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            hold_cnt_q   <= '0;
            last_q       <= SEL_B;
            sel_q        <= SEL_A;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            last_q       <= last_d;
            sel_q        <= sel_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign gnt_a      = (state_q == GNT_A);
    assign gnt_b      = (state_q == GNT_B);
    assign sel        = sel_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

endmodule : mux_arbiter_2to1

// File: tb/tb_mux_arbiter_2to1.sv
module tb_mux_arbiter_2to1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_a = 1'b0;
    logic req_b = 1'b0;
    logic [0:0] din_a = '0;
    logic [0:0] din_b = '0;
    logic gnt_a, gnt_b, sel, dout_valid;
    logic [0:0] dout;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    mux_arbiter_2to1 #(.WIDTH(1), .MAX_HOLD(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_a      (req_a),
        .req_b      (req_b),
        .din_a      (din_a),
        .din_b      (din_b),
        .gnt_a      (gnt_a),
        .gnt_b      (gnt_b),
        .sel        (sel),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

    // Stimulus-only helper: synchronous-looking reset pulse, ends on a negedge.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        req_a = 1'b1; din_a = 1'b1;
        @(negedge clk);
        n_cmp++; if (gnt_a !== 1'b1) begin n_err++; $display("FAIL single_gnt_a: got %b expected 1", gnt_a); end
        n_cmp++; if (sel !== 1'b0) begin n_err++; $display("FAIL single_sel: got %b expected 0", sel); end
        n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL single_valid_early: got %b expected 0", dout_valid); end
        @(negedge clk);
        n_cmp++; if (dout !== 1'b1) begin n_err++; $display("FAIL single_dout: got %b expected 1", dout); end
        n_cmp++; if (dout_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b expected 1", dout_valid); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_cmp++; if (gnt_a !== 1'b1 || gnt_b !== 1'b0) begin
                n_err++; $display("FAIL single_hold[%0d]: got a=%b b=%b expected a=1 b=0", i, gnt_a, gnt_b);
            end
        end
        req_a = 1'b0;
        @(negedge clk);
        n_cmp++; if (gnt_a !== 1'b0) begin n_err++; $display("FAIL release_gnt: got %b expected 0", gnt_a); end
        n_cmp++; if (dout_valid !== 1'b1) begin n_err++; $display("FAIL release_valid_tail: got %b expected 1", dout_valid); end
        @(negedge clk);
        n_cmp++; if (dout_valid !== 1'b0) begin n_err++; $display("FAIL release_valid: got %b expected 0", dout_valid); end
        n_cmp++; if (dout !== 1'b1) begin n_err++; $display("FAIL release_dout_hold: got %b expected 1", dout); end
    endtask

    task automatic test_reset();
        // dout is 1 here from the previous scenario; reset must clear it at once.
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        n_cmp++; if (dout !== 1'b0) begin n_err++; $display("FAIL reset_async_dout: got %b expected 0", dout); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++; if ({gnt_a, gnt_b, sel, dout, dout_valid} !== 5'b0) begin
                n_err++; $display("FAIL reset_idle[%0d]: got %b expected 00000", i, {gnt_a, gnt_b, sel, dout, dout_valid});
            end
        end
    endtask

    task automatic test_tie_alternate();
        logic exp_a, prev_a;
        do_reset();
        din_a = 1'b1; din_b = 1'b0;
        req_a = 1'b1; req_b = 1'b1;
        prev_a = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            exp_a = ((k / 4) % 2) == 0;
            n_cmp++; if (gnt_a !== exp_a || gnt_b !== !exp_a || sel !== !exp_a) begin
                n_err++; $display("FAIL tie_grant[%0d]: got a=%b b=%b sel=%b expected a=%b b=%b sel=%b",
                                  k, gnt_a, gnt_b, sel, exp_a, !exp_a, !exp_a);
            end
            if (k > 0) begin
                n_cmp++; if (dout_valid !== 1'b1 || dout !== prev_a) begin
                    n_err++; $display("FAIL tie_data[%0d]: got v=%b d=%b expected v=1 d=%b", k, dout_valid, dout, prev_a);
                end
            end
            prev_a = exp_a;
        end
        req_a = 1'b0; req_b = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        din_a = 1'b1; din_b = 1'b0;
        req_a = 1'b1;
        @(negedge clk);
        n_cmp++; if (gnt_a !== 1'b1) begin n_err++; $display("FAIL b2b_start: got %b expected 1", gnt_a); end
        req_b = 1'b1;
        @(negedge clk);
        n_cmp++; if (gnt_a !== 1'b1 || dout_valid !== 1'b1) begin
            n_err++; $display("FAIL b2b_hold: got a=%b v=%b expected a=1 v=1", gnt_a, dout_valid);
        end
        req_a = 1'b0;
        @(negedge clk);
        n_cmp++; if (gnt_b !== 1'b1 || gnt_a !== 1'b0 || sel !== 1'b1) begin
            n_err++; $display("FAIL b2b_handover: got a=%b b=%b sel=%b expected a=0 b=1 sel=1", gnt_a, gnt_b, sel);
        end
        n_cmp++; if (dout_valid !== 1'b1 || dout !== 1'b1) begin
            n_err++; $display("FAIL b2b_data_a: got v=%b d=%b expected v=1 d=1", dout_valid, dout);
        end
        @(negedge clk);
        n_cmp++; if (gnt_b !== 1'b1 || dout_valid !== 1'b1 || dout !== 1'b0) begin
            n_err++; $display("FAIL b2b_data_b: got b=%b v=%b d=%b expected b=1 v=1 d=0", gnt_b, dout_valid, dout);
        end
    endtask

    task automatic test_reset_mid_grant();
        // Continues with B owning the lane; make dout nonzero first.
        din_b = 1'b1;
        @(negedge clk);
        n_cmp++; if (gnt_b !== 1'b1 || dout !== 1'b1 || sel !== 1'b1) begin
            n_err++; $display("FAIL midrst_pre: got b=%b d=%b sel=%b expected b=1 d=1 sel=1", gnt_b, dout, sel);
        end
        req_a = 1'b1;
        #2 rst = 1'b1;
        #1;
        n_cmp++; if ({gnt_a, gnt_b, sel, dout, dout_valid} !== 5'b0) begin
            n_err++; $display("FAIL midrst_async: got %b expected 00000", {gnt_a, gnt_b, sel, dout, dout_valid});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (gnt_a !== 1'b1 || gnt_b !== 1'b0 || sel !== 1'b0) begin
            n_err++; $display("FAIL midrst_tie: got a=%b b=%b sel=%b expected a=1 b=0 sel=0", gnt_a, gnt_b, sel);
        end
        req_a = 1'b0; req_b = 1'b0;
    endtask

    initial begin
        #12 rst = 1'b0;
        test_single();
        test_reset();
        test_tie_alternate();
        test_back_to_back();
        test_reset_mid_grant();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_mux_arbiter_2to1
